// File: rtl/io_blocks_pkg.sv
// rtl/io_blocks_pkg.sv - shared types and constants for the link alignment sequencer
package io_blocks_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SELECT   = 4'd1,
        ST_RESET    = 4'd2,
        ST_WAIT_RDY = 4'd3,
        ST_CLEAR    = 4'd4,
        ST_DWELL    = 4'd5,
        ST_LATCH    = 4'd6,
        ST_SETTLE   = 4'd7,
        ST_GRADE    = 4'd8,
        ST_DONE     = 4'd9
    } align_state_t;

    localparam int SETTLE_CYCLES = 2;
    // Wide enough for the default 2**20-cycle ready timeout.
    localparam int DEF_TMR_W     = 21;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/link_align_sequencer_timer.sv
// rtl/link_align_sequencer_timer.sv - loadable saturating down-counter with zero flag
module align_timer
    import io_blocks_pkg::*;
#(
    parameter int W = DEF_TMR_W
) (
    input  logic         clk160,
    input  logic         rstb,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Holds at zero instead of wrapping so a late consumer still sees the expiry.
    always_ff @(posedge clk160 or negedge rstb) begin
        if (!rstb) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/link_align_sequencer.sv
// rtl/link_align_sequencer.sv - walks enabled links through reset, delay search, dwell and grading
module link_align_sequencer
    import io_blocks_pkg::*;
#(
    parameter int NLINKS       = 12,
    parameter int CNT_W        = 32,
    parameter int RST_CYCLES   = 16,
    parameter int READY_TMO    = 2**20,
    parameter int DWELL_CYCLES = 2**16,
    parameter int MIN_BITS     = 2**18,
    parameter int MAX_RETRY    = 2,
    localparam int CUR_W       = (NLINKS > 1) ? $clog2(NLINKS) : 1
) (
    input  logic                    clk160,
    input  logic                    rstb,
    input  logic                    start,
    input  logic [NLINKS-1:0]       link_mask,
    input  logic [NLINKS-1:0]       delay_ready,
    input  logic [NLINKS-1:0]       waiting_trans,
    input  logic [NLINKS*CNT_W-1:0] bit_count,
    input  logic [NLINKS*CNT_W-1:0] err_count,
    output logic [NLINKS-1:0]       link_resetn,
    output logic [NLINKS-1:0]       counter_reset,
    output logic [NLINKS-1:0]       latch_counters,
    output logic [NLINKS-1:0]       delay_mode,
    output logic                    busy,
    output logic                    done,
    output logic [CUR_W-1:0]        cur_link,
    output logic [NLINKS-1:0]       link_pass,
    output logic [NLINKS-1:0]       link_fail,
    output logic [NLINKS-1:0]       fail_no_trans
);

    localparam int TMR_MAX = max_of(max_of(RST_CYCLES, READY_TMO), max_of(DWELL_CYCLES, SETTLE_CYCLES));
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int ATT_W   = $clog2(MAX_RETRY + 1) + 1;

    // Timers are loaded with N-1 so a state holding until zero lasts exactly N cycles.
    localparam logic [TMR_W-1:0] RST_LOAD    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LOAD    = TMR_W'(READY_TMO - 1);
    localparam logic [TMR_W-1:0] DWELL_LOAD  = TMR_W'(DWELL_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

    align_state_t       state, state_nxt;
    logic [NLINKS-1:0]  mask_q;
    logic [ATT_W-1:0]   attempts;
    logic [ATT_W-1:0]   att_nxt;
    logic               retry_ok;

    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_zero;

    logic [NLINKS-1:0]  cand;
    logic [CUR_W-1:0]   sel_idx;
    logic               sel_found;
    logic [NLINKS-1:0]  cur_oh;
    logic [CNT_W-1:0]   cur_bits;
    logic [CNT_W-1:0]   cur_errs;
    logic               grade_ok;

    logic               begin_pass;
    logic               sel_take;
    logic               attempt_fail;
    logic               fail_nt;
    logic               set_pass;

    align_timer #(.W(TMR_W)) u_timer (
        .clk160   (clk160),
        .rstb     (rstb),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Lowest-index link that is enabled for this pass and not yet graded.
    always_comb begin
        cand      = mask_q & ~(link_pass | link_fail);
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = NLINKS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_idx   = CUR_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        cur_oh           = '0;
        cur_oh[cur_link] = 1'b1;
        cur_bits         = bit_count[int'(cur_link) * CNT_W +: CNT_W];
        cur_errs         = err_count[int'(cur_link) * CNT_W +: CNT_W];
        grade_ok         = (cur_errs == '0) && (cur_bits >= CNT_W'(MIN_BITS));
        att_nxt          = attempts + ATT_W'(1);
        retry_ok         = (att_nxt <= ATT_W'(MAX_RETRY));
    end

    always_ff @(posedge clk160 or negedge rstb) begin
        if (!rstb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        begin_pass   = 1'b0;
        sel_take     = 1'b0;
        attempt_fail = 1'b0;
        fail_nt      = 1'b0;
        set_pass     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    begin_pass = 1'b1;
                    state_nxt  = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (sel_found) begin
                    sel_take  = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = RST_LOAD;
                    state_nxt = ST_RESET;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_RESET: begin
                if (tmr_zero) begin
                    tmr_load  = 1'b1;
                    tmr_val   = TMO_LOAD;
                    state_nxt = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (delay_ready[cur_link]) begin
                    state_nxt = ST_CLEAR;
                end else if (tmr_zero) begin
                    attempt_fail = 1'b1;
                    fail_nt      = waiting_trans[cur_link];
                end
            end
            ST_CLEAR: begin
                tmr_load  = 1'b1;
                tmr_val   = DWELL_LOAD;
                state_nxt = ST_DWELL;
            end
            ST_DWELL: begin
                if (tmr_zero) begin
                    state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                tmr_load  = 1'b1;
                tmr_val   = SETTLE_LOAD;
                state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_nxt = ST_GRADE;
                end
            end
            ST_GRADE: begin
                if (grade_ok) begin
                    set_pass  = 1'b1;
                    state_nxt = ST_SELECT;
                end else begin
                    attempt_fail = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Timeout and grading failures share one retry path back to RESET.
        if (attempt_fail) begin
            if (retry_ok) begin
                tmr_load  = 1'b1;
                tmr_val   = RST_LOAD;
                state_nxt = ST_RESET;
            end else begin
                state_nxt = ST_SELECT;
            end
        end
    end

    always_ff @(posedge clk160 or negedge rstb) begin
        if (!rstb) begin
            mask_q        <= '0;
            cur_link      <= '0;
            attempts      <= '0;
            link_pass     <= '0;
            link_fail     <= '0;
            fail_no_trans <= '0;
            delay_mode    <= '0;
        end else begin
            if (begin_pass) begin
                mask_q        <= link_mask;
                link_pass     <= '0;
                link_fail     <= '0;
                fail_no_trans <= '0;
            end
            if (sel_take) begin
                cur_link            <= sel_idx;
                attempts            <= '0;
                delay_mode[sel_idx] <= 1'b1;
            end
            if (set_pass) begin
                link_pass[cur_link] <= 1'b1;
            end
            // The no-transition flag is only recorded on the final attempt so it always implies link_fail.
            if (attempt_fail) begin
                if (retry_ok) begin
                    attempts <= att_nxt;
                end else begin
                    link_fail[cur_link]     <= 1'b1;
                    fail_no_trans[cur_link] <= fail_nt;
                end
            end
        end
    end

    assign busy           = (state != ST_IDLE) && (state != ST_DONE);
    assign done           = (state == ST_DONE);
    assign link_resetn    = ~(cur_oh & {NLINKS{state == ST_RESET}});
    assign counter_reset  = cur_oh & {NLINKS{state == ST_CLEAR}};
    assign latch_counters = cur_oh & {NLINKS{state == ST_LATCH}};

endmodule

// File: tb/tb_link_align_sequencer.sv
// tb/tb_link_align_sequencer.sv - randomized scoreboard bench for link_align_sequencer
module tb_link_align_sequencer;

    localparam int NL        = 4;
    localparam int CW        = 32;
    localparam int MIN_BITS  = 100;
    localparam int MAX_RETRY = 1;

    typedef struct {
        logic [3:0]      pass;
        logic [3:0]      fail;
        logic [3:0]      nt;
        logic [3:0]      dm;
        logic [3:0][3:0] att;
        int              lat;
        int              bsy;
    } exp_t;

    logic              clk = 1'b0;
    logic              rstb;
    logic              start;
    logic [NL-1:0]     link_mask;
    logic [NL-1:0]     delay_ready;
    logic [NL-1:0]     wt_v;
    logic [NL*CW-1:0]  bit_count;
    logic [NL*CW-1:0]  err_count;
    logic [NL-1:0]     link_resetn;
    logic [NL-1:0]     counter_reset;
    logic [NL-1:0]     latch_counters;
    logic [NL-1:0]     delay_mode;
    logic              busy;
    logic              done;
    logic [1:0]        cur_link;
    logic [NL-1:0]     link_pass;
    logic [NL-1:0]     link_fail;
    logic [NL-1:0]     fail_no_trans;

    int                rd_dly [NL];
    int unsigned       bits_a [NL][2];
    int unsigned       err_a  [NL][2];
    int                rd_cnt [NL];
    int                lat_n  [NL];
    bit                pend   [NL];

    exp_t              exp_q[$];
    logic [3:0]        model_dm;
    int                checks = 0;
    int                failures = 0;

    link_align_sequencer #(
        .NLINKS(NL), .CNT_W(CW), .RST_CYCLES(4), .READY_TMO(64),
        .DWELL_CYCLES(32), .MIN_BITS(MIN_BITS), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk160(clk), .rstb(rstb), .start(start), .link_mask(link_mask),
        .delay_ready(delay_ready), .waiting_trans(wt_v),
        .bit_count(bit_count), .err_count(err_count),
        .link_resetn(link_resetn), .counter_reset(counter_reset),
        .latch_counters(latch_counters), .delay_mode(delay_mode),
        .busy(busy), .done(done), .cur_link(cur_link),
        .link_pass(link_pass), .link_fail(link_fail), .fail_no_trans(fail_no_trans)
    );

    always #5 clk = ~clk;

    // Link environment: delay search finishes rd_dly cycles after reset release; counters appear one cycle after latch.
    always @(negedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (!busy) begin
                lat_n[i] = 0;
                pend[i]  = 1'b0;
                bit_count[i*CW +: CW] = '0;
                err_count[i*CW +: CW] = '0;
            end else begin
                if (pend[i]) begin
                    bit_count[i*CW +: CW] = bits_a[i][lat_n[i]];
                    err_count[i*CW +: CW] = err_a[i][lat_n[i]];
                    if (lat_n[i] < 1) lat_n[i]++;
                    pend[i] = 1'b0;
                end
                if (latch_counters[i]) pend[i] = 1'b1;
            end
            if (!link_resetn[i]) begin
                delay_ready[i] = 1'b0;
                rd_cnt[i]      = 0;
            end else if (rd_dly[i] >= 0 && !delay_ready[i]) begin
                if (rd_cnt[i] >= rd_dly[i]) delay_ready[i] = 1'b1;
                else rd_cnt[i]++;
            end
        end
    end

    // Reference: each masked link gets up to MAX_RETRY+1 attempts; an attempt passes when the
    // delay search completes and that attempt's counters show zero errors and enough bits.
    function automatic exp_t model(input logic [3:0] m, input logic [3:0] dm_prev);
        exp_t e;
        bit   ok;
        bit   stop;
        e.pass = '0; e.fail = '0; e.nt = '0; e.att = '0;
        e.dm   = dm_prev | m;
        e.lat  = (m == 4'b0) ? 2 : -1;
        e.bsy  = 1;
        for (int i = 0; i < NL; i++) begin
            stop = 1'b0;
            if (m[i]) begin
                for (int a = 0; a <= MAX_RETRY; a++) begin
                    if (!stop) begin
                        e.att[i] = e.att[i] + 4'd1;
                        ok = (rd_dly[i] >= 0) && (err_a[i][a] == 0) && (bits_a[i][a] >= MIN_BITS);
                        if (ok) begin
                            e.pass[i] = 1'b1;
                            stop = 1'b1;
                        end else if (a == MAX_RETRY) begin
                            e.fail[i] = 1'b1;
                            e.nt[i]   = (rd_dly[i] < 0) && wt_v[i];
                        end
                    end
                end
            end
        end
        return e;
    endfunction

    // Monitor / scoreboard
    logic [3:0]      act_mask = '0;
    logic [3:0]      prev_rn  = '1;
    logic [3:0][3:0] eps      = '0;
    int              cyc = 0;
    int              bsy_n = 0;
    int              wd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] tgt;
        logic [5:0] viol;
        exp_t       e;
        if (!rstb) begin
            chk("reset_values",
                {link_resetn, counter_reset, latch_counters, delay_mode, busy, done, cur_link,
                 link_pass, link_fail, fail_no_trans},
                {4'hf, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b0, 4'h0, 4'h0, 4'h0});
            exp_q.delete();
            eps = '0; prev_rn = '1; wd = 0; act_mask = '0;
        end else begin
            for (int i = 0; i < NL; i++)
                if (prev_rn[i] && !link_resetn[i]) eps[i] = eps[i] + 4'd1;
            prev_rn = link_resetn;

            tgt  = ~link_resetn | counter_reset | latch_counters;
            viol = {(link_pass & link_fail) != 0, (fail_no_trans & ~link_fail) != 0, !$onehot0(tgt),
                    (tgt & ~act_mask) != 0, (tgt & ~(4'b0001 << cur_link)) != 0, busy && done};
            chk("invariants", 32'(viol), 32'h0);

            if (start && !busy && !done) begin
                act_mask = link_mask;
                cyc = 0; bsy_n = 0; eps = '0;
            end else begin
                cyc++;
            end
            if (busy) bsy_n++;

            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("link_pass", 32'(link_pass), 32'(e.pass));
                    chk("link_fail", 32'(link_fail), 32'(e.fail));
                    chk("fail_no_trans", 32'(fail_no_trans), 32'(e.nt));
                    chk("delay_mode", 32'(delay_mode), 32'(e.dm));
                    chk("reset_episodes", 32'(eps), 32'(e.att));
                    if (e.lat >= 0) begin
                        chk("done_latency", 32'(cyc), 32'(e.lat));
                        chk("busy_cycles", 32'(bsy_n), 32'(e.bsy));
                    end
                end
                eps = '0;
            end

            if (exp_q.size() != 0) wd++;
            else wd = 0;
            if (wd > 3500) begin
                chk("done_timeout", 32'h1, 32'h0);
                exp_q.delete();
                wd = 0;
            end
        end
    end

    // Stimulus
    task automatic set_all(input int dly, input logic w, input int unsigned bits, input int unsigned err);
        for (int i = 0; i < NL; i++) begin
            rd_dly[i] = dly; wt_v[i] = w;
            bits_a[i][0] = bits; bits_a[i][1] = bits;
            err_a[i][0]  = err;  err_a[i][1]  = err;
        end
    endtask

    task automatic gen_cfg();
        for (int i = 0; i < NL; i++) begin
            rd_dly[i] = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 40));
            wt_v[i]   = 1'($urandom_range(0, 1));
            for (int a = 0; a < 2; a++) begin
                case ($urandom_range(0, 3))
                    0: bits_a[i][a] = 99;
                    1: bits_a[i][a] = 100;
                    2: bits_a[i][a] = 256;
                    default: bits_a[i][a] = $urandom_range(0, 300);
                endcase
                err_a[i][a] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            end
        end
    endtask

    task automatic run_pass(input logic [3:0] m, input bit inject);
        exp_t e;
        @(posedge clk); #1;
        link_mask = m;
        e = model(m, model_dm);
        model_dm = e.dm;
        exp_q.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (inject) begin
            repeat (20) @(posedge clk);
            #1; start = 1'b1; link_mask = ~m;
            @(posedge clk); #1;
            start = 1'b0; link_mask = m;
        end
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (done) break;
        end
    endtask

    initial begin
        rstb = 1'b0; start = 1'b0; link_mask = '0;
        delay_ready = '0; bit_count = '0; err_count = '0;
        model_dm = '0;
        for (int i = 0; i < NL; i++) begin rd_cnt[i] = 0; lat_n[i] = 0; pend[i] = 1'b0; end
        set_all(10, 1'b0, 256, 0);
        repeat (3) @(posedge clk);
        #1 rstb = 1'b1;

        set_all(10, 1'b0, 256, 0);
        run_pass(4'b0101, 1'b0);

        set_all(10, 1'b0, 256, 0);
        rd_dly[0] = -1; wt_v[0] = 1'b1;
        run_pass(4'b0001, 1'b0);

        set_all(10, 1'b0, 256, 0);
        err_a[0][0] = 5;
        run_pass(4'b0001, 1'b0);

        set_all(10, 1'b0, 256, 0);
        bits_a[0][0] = 99;  bits_a[0][1] = 99;
        bits_a[1][0] = 100; bits_a[1][1] = 100;
        run_pass(4'b0011, 1'b0);

        run_pass(4'b0000, 1'b0);

        gen_cfg();
        run_pass(4'b1111, 1'b1);

        for (int k = 0; k < 10; k++) begin
            gen_cfg();
            run_pass(4'($urandom_range(0, 15)), 1'b0);
        end

        set_all(5, 1'b0, 256, 0);
        @(posedge clk); #1;
        link_mask = 4'b1111;
        start = 1'b1;
        exp_q.push_back(model(4'b1111, model_dm));
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (counter_reset != 0) break;
        end
        repeat (5) @(posedge clk);
        #1 rstb = 1'b0;
        model_dm = '0;
        repeat (2) @(posedge clk);
        #1 rstb = 1'b1;

        gen_cfg();
        run_pass(4'b1011, 1'b0);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
